// File: rtl/uart_pkg.sv
// Shared definitions for the UART debug link: command/address encodings,
// per-register payload lengths and the command-byte helpers.
package uart_pkg;

  localparam int IRLENGTH  = 5;
  localparam int CMDLENGTH = 3;

  localparam logic [CMDLENGTH-1:0] CMD_NOP       = 3'd0;
  localparam logic [CMDLENGTH-1:0] CMD_WRITE     = 3'd1;
  localparam logic [CMDLENGTH-1:0] CMD_READ      = 3'd2;
  localparam logic [CMDLENGTH-1:0] CMD_CONT_READ = 3'd3;
  localparam logic [CMDLENGTH-1:0] CMD_RESET     = 3'd4;

  localparam logic [IRLENGTH-1:0] ADDR_BYPASS = 5'h00;
  localparam logic [IRLENGTH-1:0] ADDR_IDCODE = 5'h01;
  localparam logic [IRLENGTH-1:0] ADDR_DTMCS  = 5'h10;
  localparam logic [IRLENGTH-1:0] ADDR_DMI    = 5'h11;

  typedef enum logic [1:0] {TX_IDLE, TX_CMD, TX_DATA, TX_GAP} tx_state_e;
  typedef enum logic [1:0] {RX_ADDR, RX_DATA, RX_RESP} rx_state_e;

  function automatic int get_write_length(input logic [IRLENGTH-1:0] addr);
    int len;
    len = 0;
    case (addr)
      ADDR_DTMCS: len = 32;
      ADDR_DMI:   len = 41;
      default:    len = 0;
    endcase
    return len;
  endfunction

  function automatic int get_read_length(input logic [IRLENGTH-1:0] addr);
    int len;
    len = 0;
    case (addr)
      ADDR_IDCODE: len = 32;
      ADDR_DTMCS:  len = 32;
      ADDR_DMI:    len = 34;
      default:     len = 0;
    endcase
    return len;
  endfunction

  function automatic int get_write_bytes(input logic [IRLENGTH-1:0] addr);
    return (get_write_length(addr) + 7) / 8;
  endfunction

  function automatic int get_read_bytes(input logic [IRLENGTH-1:0] addr);
    return (get_read_length(addr) + 7) / 8;
  endfunction

  function automatic logic [7:0] pack_command(input logic [CMDLENGTH-1:0] cmd,
                                              input logic [IRLENGTH-1:0]  addr);
    return {cmd, addr};
  endfunction

  function automatic logic [IRLENGTH-1:0] unpack_addr(input logic [7:0] cmd_byte);
    return cmd_byte[IRLENGTH-1:0];
  endfunction

  function automatic logic [CMDLENGTH-1:0] unpack_cmd(input logic [7:0] cmd_byte);
    return cmd_byte[7 -: CMDLENGTH];
  endfunction

endpackage

// File: rtl/dmi_uart_host_rx.sv
// Receive path of the host: tracks the target's current read address and
// reassembles little-endian read bytes into ready/valid response words.
module dmi_uart_host_rx
  import uart_pkg::*;
#(
  parameter int WIDTH = get_write_length(ADDR_DMI)
) (
  input  logic                CLK_I,
  input  logic                RST_NI,
  output logic                READ_O,
  input  logic [7:0]          DATA_REC_I,
  input  logic                RX_EMPTY_I,
  input  logic                CMD_REC_I,
  output logic                RSP_VALID_O,
  input  logic                RSP_READY_I,
  output logic [IRLENGTH-1:0] RSP_ADDRESS_O,
  output logic [WIDTH-1:0]    RSP_DATA_O,
  output logic                ADDR_UPDATE_O
);

  rx_state_e           rx_state;
  logic [IRLENGTH-1:0] addr_q;
  logic [WIDTH-1:0]    asm_q;
  logic [7:0]          idx_q;

  logic [WIDTH-1:0] rd_mask;
  logic [WIDTH-1:0] asm_next;
  logic             last_byte;
  logic             cmd_has_data;

  // NOTE: every variable driven in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old one.
  always_comb begin
    rd_mask      = ~({WIDTH{1'b1}} << get_read_length(addr_q));
    asm_next     = (asm_q | (WIDTH'(DATA_REC_I) << (8 * int'(idx_q)))) & rd_mask;
    last_byte    = (int'(idx_q) + 1 == get_read_bytes(addr_q));
    cmd_has_data = (get_read_bytes(unpack_addr(DATA_REC_I)) != 0);
  end

  // Bytes stay in the FIFO while a response waits, which is the backpressure.
  assign READ_O        = RST_NI && !RX_EMPTY_I && (rx_state != RX_RESP);
  assign RSP_VALID_O   = (rx_state == RX_RESP);
  assign RSP_ADDRESS_O = addr_q;
  assign RSP_DATA_O    = asm_q;

  always_ff @(posedge CLK_I) begin
    if (!RST_NI) begin
      rx_state      <= RX_ADDR;
      addr_q        <= ADDR_IDCODE;
      // NOTE: the assembly register is reset because it drives RSP_DATA_O directly.
      asm_q         <= '0;
      idx_q         <= '0;
      ADDR_UPDATE_O <= 1'b0;
    end else begin
      ADDR_UPDATE_O <= 1'b0;
      case (rx_state)
        RX_ADDR, RX_DATA: begin
          if (READ_O) begin
            if (CMD_REC_I) begin
              // A command byte always restarts assembly, dropping any partial word.
              addr_q        <= unpack_addr(DATA_REC_I);
              ADDR_UPDATE_O <= 1'b1;
              asm_q         <= '0;
              idx_q         <= '0;
              rx_state      <= cmd_has_data ? RX_DATA : RX_ADDR;
            end else if (rx_state == RX_DATA) begin
              asm_q <= asm_next;
              idx_q <= idx_q + 8'd1;
              if (last_byte) rx_state <= RX_RESP;
            end
          end
        end
        RX_RESP: begin
          if (RSP_READY_I) begin
            asm_q    <= '0;
            idx_q    <= '0;
            rx_state <= RX_DATA;
          end
        end
        default: rx_state <= RX_ADDR;
      endcase
    end
  end

endmodule

// File: rtl/dmi_uart_host.sv
// Host-side initiator for the UART debug link: serialises register requests
// into command + payload bytes and returns reassembled read data.
module dmi_uart_host
  import uart_pkg::*;
#(
  parameter int WIDTH = get_write_length(ADDR_DMI)
) (
  input  logic                 CLK_I,
  input  logic                 RST_NI,
  input  logic                 REQ_VALID_I,
  output logic                 REQ_READY_O,
  input  logic [CMDLENGTH-1:0] REQ_COMMAND_I,
  input  logic [IRLENGTH-1:0]  REQ_ADDRESS_I,
  input  logic [WIDTH-1:0]     REQ_DATA_I,
  output logic                 RSP_VALID_O,
  input  logic                 RSP_READY_I,
  output logic [IRLENGTH-1:0]  RSP_ADDRESS_O,
  output logic [WIDTH-1:0]     RSP_DATA_O,
  output logic                 ADDR_UPDATE_O,
  output logic                 READ_O,
  input  logic [7:0]           DATA_REC_I,
  input  logic                 RX_EMPTY_I,
  input  logic                 CMD_REC_I,
  input  logic                 TX_READY_I,
  output logic                 WRITE_O,
  output logic [7:0]           DATA_SEND_O,
  output logic                 SEND_COMMAND_O,
  output logic [7:0]           COMMAND_O
);

  tx_state_e            tx_state;
  logic [CMDLENGTH-1:0] tx_cmd;
  logic [IRLENGTH-1:0]  tx_addr;
  logic [WIDTH-1:0]     tx_data;
  logic [7:0]           tx_cnt;
  logic                 req_ready_q;
  logic [WIDTH-1:0]     wr_mask;

  always_comb wr_mask = ~({WIDTH{1'b1}} << get_write_length(REQ_ADDRESS_I));

  assign REQ_READY_O = req_ready_q;

  // NOTE: the reset branch is sampled on the clock edge only; RST_NI is not in
  // the sensitivity list.
  always_ff @(posedge CLK_I) begin
    if (!RST_NI) begin
      tx_state       <= TX_IDLE;
      tx_cmd         <= CMD_NOP;
      tx_addr        <= '0;
      tx_data        <= '0;
      tx_cnt         <= '0;
      req_ready_q    <= 1'b0;
      WRITE_O        <= 1'b0;
      DATA_SEND_O    <= '0;
      SEND_COMMAND_O <= 1'b0;
      COMMAND_O      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      WRITE_O        <= 1'b0;
      SEND_COMMAND_O <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (req_ready_q && REQ_VALID_I) begin
            tx_cmd      <= REQ_COMMAND_I;
            tx_addr     <= REQ_ADDRESS_I;
            tx_data     <= REQ_DATA_I & wr_mask;
            tx_cnt      <= 8'(get_write_bytes(REQ_ADDRESS_I));
            req_ready_q <= 1'b0;
            tx_state    <= TX_CMD;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        TX_CMD: begin
          if (TX_READY_I) begin
            SEND_COMMAND_O <= 1'b1;
            COMMAND_O      <= pack_command(tx_cmd, tx_addr);
            tx_state       <= TX_GAP;
          end
        end
        TX_DATA: begin
          if (TX_READY_I) begin
            WRITE_O     <= 1'b1;
            DATA_SEND_O <= tx_data[7:0];
            tx_data     <= tx_data >> 8;
            tx_cnt      <= tx_cnt - 8'd1;
            tx_state    <= TX_GAP;
          end
        end
        TX_GAP: begin
          // One dead cycle so the UART can drop TX_READY_I before the next strobe.
          if (tx_cmd == CMD_WRITE && tx_cnt != 8'd0) begin
            tx_state <= TX_DATA;
          end else begin
            tx_state    <= TX_IDLE;
            req_ready_q <= 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  dmi_uart_host_rx #(.WIDTH(WIDTH)) u_rx (
    .CLK_I         (CLK_I),
    .RST_NI        (RST_NI),
    .READ_O        (READ_O),
    .DATA_REC_I    (DATA_REC_I),
    .RX_EMPTY_I    (RX_EMPTY_I),
    .CMD_REC_I     (CMD_REC_I),
    .RSP_VALID_O   (RSP_VALID_O),
    .RSP_READY_I   (RSP_READY_I),
    .RSP_ADDRESS_O (RSP_ADDRESS_O),
    .RSP_DATA_O    (RSP_DATA_O),
    .ADDR_UPDATE_O (ADDR_UPDATE_O)
  );

endmodule

// File: tb/tb_dmi_uart_host.sv
// Directed bench for dmi_uart_host: TX framing/throttling, RX assembly,
// backpressure, abort and mid-transfer reset.
module tb_dmi_uart_host;
  import uart_pkg::*;

  localparam int W = 41;

  logic                 CLK_I, RST_NI;
  logic                 REQ_VALID_I, REQ_READY_O;
  logic [CMDLENGTH-1:0] REQ_COMMAND_I;
  logic [IRLENGTH-1:0]  REQ_ADDRESS_I;
  logic [W-1:0]         REQ_DATA_I;
  logic                 RSP_VALID_O, RSP_READY_I;
  logic [IRLENGTH-1:0]  RSP_ADDRESS_O;
  logic [W-1:0]         RSP_DATA_O;
  logic                 ADDR_UPDATE_O, READ_O;
  logic [7:0]           DATA_REC_I;
  logic                 RX_EMPTY_I, CMD_REC_I, TX_READY_I;
  logic                 WRITE_O, SEND_COMMAND_O;
  logic [7:0]           DATA_SEND_O, COMMAND_O;

  int tests_run = 0;
  int tests_failed = 0;

  // RX FIFO model: first-word-fall-through, {cmd_flag, byte}
  logic [8:0] rx_mem [0:255];
  int rx_wr = 0;
  int rx_rd = 0;
  assign DATA_REC_I = rx_mem[rx_rd[7:0]][7:0];
  assign CMD_REC_I  = rx_mem[rx_rd[7:0]][8];
  assign RX_EMPTY_I = (rx_rd == rx_wr);
  always @(posedge CLK_I) if (READ_O) rx_rd <= rx_rd + 1;

  // TX capture
  logic [7:0] tx_bytes[$];
  logic [7:0] tx_cmds[$];
  int tx_cycles, cmd_cycle, gap_err, low_err;
  bit tx_timeout;

  dmi_uart_host #(.WIDTH(W)) dut (
    .CLK_I(CLK_I), .RST_NI(RST_NI),
    .REQ_VALID_I(REQ_VALID_I), .REQ_READY_O(REQ_READY_O),
    .REQ_COMMAND_I(REQ_COMMAND_I), .REQ_ADDRESS_I(REQ_ADDRESS_I), .REQ_DATA_I(REQ_DATA_I),
    .RSP_VALID_O(RSP_VALID_O), .RSP_READY_I(RSP_READY_I),
    .RSP_ADDRESS_O(RSP_ADDRESS_O), .RSP_DATA_O(RSP_DATA_O),
    .ADDR_UPDATE_O(ADDR_UPDATE_O), .READ_O(READ_O),
    .DATA_REC_I(DATA_REC_I), .RX_EMPTY_I(RX_EMPTY_I), .CMD_REC_I(CMD_REC_I),
    .TX_READY_I(TX_READY_I), .WRITE_O(WRITE_O), .DATA_SEND_O(DATA_SEND_O),
    .SEND_COMMAND_O(SEND_COMMAND_O), .COMMAND_O(COMMAND_O)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge CLK_I);
    #1;
  endtask

  task automatic push(input logic is_cmd, input logic [7:0] b);
    rx_mem[rx_wr[7:0]] = {is_cmd, b};
    rx_wr = rx_wr + 1;
  endtask

  task automatic send_req(input logic [CMDLENGTH-1:0] cmd, input logic [IRLENGTH-1:0] addr,
                          input logic [W-1:0] data, output bit ok);
    bit rdy;
    ok = 0;
    REQ_COMMAND_I = cmd;
    REQ_ADDRESS_I = addr;
    REQ_DATA_I    = data;
    REQ_VALID_I   = 1'b1;
    for (int i = 0; i < 50; i++) begin
      rdy = REQ_READY_O;
      tick;
      if (rdy) begin
        ok = 1;
        break;
      end
    end
    REQ_VALID_I = 1'b0;
  endtask

  // Runs from the handshake edge until REQ_READY_O returns, logging strobes.
  task automatic collect_tx(input bit throttle, input int budget);
    bit rdy_before, strobe, prev_strobe;
    tx_bytes.delete();
    tx_cmds.delete();
    gap_err = 0; low_err = 0; tx_cycles = 0; cmd_cycle = -1;
    tx_timeout = 1; prev_strobe = 0;
    for (int c = 0; c < budget; c++) begin
      TX_READY_I = throttle ? (c % 4 == 3) : 1'b1;
      rdy_before = TX_READY_I;
      tick;
      strobe = WRITE_O | SEND_COMMAND_O;
      if (strobe && !rdy_before) low_err++;
      if (strobe && prev_strobe) gap_err++;
      if (SEND_COMMAND_O) begin
        tx_cmds.push_back(COMMAND_O);
        if (cmd_cycle < 0) cmd_cycle = c + 1;
      end
      if (WRITE_O) tx_bytes.push_back(DATA_SEND_O);
      prev_strobe = strobe;
      tx_cycles = c + 1;
      if (REQ_READY_O) begin
        tx_timeout = 0;
        break;
      end
    end
    TX_READY_I = 1'b1;
  endtask

  task automatic test_reset;
    RST_NI = 1'b0;
    push(1'b0, 8'h5A);
    tick; tick;
    tests_run++; if (REQ_READY_O !== 1'b0) begin tests_failed++; $display("FAIL reset_req_ready: got %b want 0", REQ_READY_O); end
    tests_run++; if ({RSP_VALID_O, WRITE_O, SEND_COMMAND_O, ADDR_UPDATE_O, READ_O} !== 5'b0) begin
      tests_failed++; $display("FAIL reset_strobes: got %b want 00000", {RSP_VALID_O, WRITE_O, SEND_COMMAND_O, ADDR_UPDATE_O, READ_O}); end
    tests_run++; if ({COMMAND_O, DATA_SEND_O} !== 16'h0 || RSP_DATA_O !== '0) begin
      tests_failed++; $display("FAIL reset_data: cmd %h data %h rsp %h want 0", COMMAND_O, DATA_SEND_O, RSP_DATA_O); end
    tests_run++; if (RSP_ADDRESS_O !== ADDR_IDCODE) begin tests_failed++; $display("FAIL reset_addr: got %h want %h", RSP_ADDRESS_O, ADDR_IDCODE); end
    RST_NI = 1'b1;
    tick;
    tests_run++; if (REQ_READY_O !== 1'b1) begin tests_failed++; $display("FAIL reset_release_ready: got %b want 1", REQ_READY_O); end
    tick;
    tests_run++; if (RX_EMPTY_I !== 1'b1 || ADDR_UPDATE_O !== 1'b0 || RSP_VALID_O !== 1'b0) begin
      tests_failed++; $display("FAIL reset_stray_byte: empty %b upd %b valid %b want 1 0 0", RX_EMPTY_I, ADDR_UPDATE_O, RSP_VALID_O); end
  endtask

  task automatic test_write_dmi;
    bit ok;
    logic [7:0] exp [6] = '{8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    send_req(CMD_WRITE, ADDR_DMI, 41'h1_2345_6789_AB, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL write_handshake: no handshake within budget"); end
    collect_tx(1'b0, 40);
    tests_run++; if (tx_timeout || tx_cycles != 14) begin tests_failed++; $display("FAIL write_duration: got %0d cycles (timeout %b) want 14", tx_cycles, tx_timeout); end
    tests_run++; if (cmd_cycle != 1) begin tests_failed++; $display("FAIL write_cmd_latency: got %0d want 1", cmd_cycle); end
    tests_run++; if (tx_cmds.size() != 1 || tx_cmds[0] !== 8'h31) begin tests_failed++; $display("FAIL write_cmd_byte: got %0d cmds first %h want 1 x 31", tx_cmds.size(), tx_cmds.size() ? tx_cmds[0] : 8'hxx); end
    tests_run++; if (tx_bytes.size() != 6) begin tests_failed++; $display("FAIL write_byte_count: got %0d want 6", tx_bytes.size()); end
    for (int i = 0; i < 6; i++) begin
      tests_run++; if (i >= tx_bytes.size() || tx_bytes[i] !== exp[i]) begin tests_failed++; $display("FAIL write_byte%0d: got %h want %h", i, i < tx_bytes.size() ? tx_bytes[i] : 8'hxx, exp[i]); end
    end
    tests_run++; if (gap_err != 0) begin tests_failed++; $display("FAIL write_gap: %0d back-to-back strobes want 0", gap_err); end
  endtask

  task automatic test_write_dtmcs_and_read;
    bit ok;
    logic [7:0] exp [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
    send_req(CMD_WRITE, ADDR_DTMCS, 41'h1_FF12_3456_78, ok);
    collect_tx(1'b0, 40);
    tests_run++; if (!ok || tx_timeout || tx_cycles != 10) begin tests_failed++; $display("FAIL dtmcs_duration: got %0d cycles ok %b want 10", tx_cycles, ok); end
    tests_run++; if (tx_cmds.size() != 1 || tx_cmds[0] !== 8'h30) begin tests_failed++; $display("FAIL dtmcs_cmd: got %0d cmds first %h want 30", tx_cmds.size(), tx_cmds.size() ? tx_cmds[0] : 8'hxx); end
    tests_run++; if (tx_bytes.size() != 4) begin tests_failed++; $display("FAIL dtmcs_byte_count: got %0d want 4", tx_bytes.size()); end
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (i >= tx_bytes.size() || tx_bytes[i] !== exp[i]) begin tests_failed++; $display("FAIL dtmcs_byte%0d: got %h want %h", i, i < tx_bytes.size() ? tx_bytes[i] : 8'hxx, exp[i]); end
    end
    send_req(CMD_READ, ADDR_DMI, 41'h1_FFFF_FFFF_FF, ok);
    collect_tx(1'b0, 40);
    tests_run++; if (!ok || tx_timeout || tx_cycles != 2) begin tests_failed++; $display("FAIL read_duration: got %0d cycles ok %b want 2", tx_cycles, ok); end
    tests_run++; if (tx_cmds.size() != 1 || tx_cmds[0] !== 8'h51 || tx_bytes.size() != 0) begin
      tests_failed++; $display("FAIL read_frame: got %0d cmds first %h and %0d bytes want 51 and 0 bytes", tx_cmds.size(), tx_cmds.size() ? tx_cmds[0] : 8'hxx, tx_bytes.size()); end
  endtask

  task automatic test_tx_throttle;
    bit ok;
    logic [7:0] exp [6] = '{8'hF0, 8'h3C, 8'hC3, 8'h55, 8'hAA, 8'h01};
    TX_READY_I = 1'b0;
    send_req(CMD_WRITE, ADDR_DMI, 41'h1_AA55_C33C_F0, ok);
    collect_tx(1'b1, 200);
    tests_run++; if (!ok || tx_timeout) begin tests_failed++; $display("FAIL throttle_done: ok %b timeout %b want 1 0", ok, tx_timeout); end
    tests_run++; if (low_err != 0) begin tests_failed++; $display("FAIL throttle_low_strobe: %0d strobes after TX_READY_I low want 0", low_err); end
    tests_run++; if (tx_cmds.size() != 1 || tx_cmds[0] !== 8'h31) begin tests_failed++; $display("FAIL throttle_cmd: got %0d cmds first %h want 31", tx_cmds.size(), tx_cmds.size() ? tx_cmds[0] : 8'hxx); end
    tests_run++; if (tx_bytes.size() != 6) begin tests_failed++; $display("FAIL throttle_byte_count: got %0d want 6", tx_bytes.size()); end
    for (int i = 0; i < 6; i++) begin
      tests_run++; if (i >= tx_bytes.size() || tx_bytes[i] !== exp[i]) begin tests_failed++; $display("FAIL throttle_byte%0d: got %h want %h", i, i < tx_bytes.size() ? tx_bytes[i] : 8'hxx, exp[i]); end
    end
  endtask

  task automatic test_rx_basic;
    int upd, vcycle;
    push(1'b1, 8'h01);
    push(1'b0, 8'hEF); push(1'b0, 8'hBE); push(1'b0, 8'hAD); push(1'b0, 8'hDE);
    upd = 0; vcycle = -1;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (ADDR_UPDATE_O) upd++;
      if (RSP_VALID_O) begin vcycle = c + 1; break; end
    end
    tests_run++; if (vcycle != 5) begin tests_failed++; $display("FAIL rx_valid_cycle: got %0d want 5", vcycle); end
    tests_run++; if (upd != 1) begin tests_failed++; $display("FAIL rx_addr_update: got %0d pulses want 1", upd); end
    tests_run++; if (RSP_ADDRESS_O !== 5'h01) begin tests_failed++; $display("FAIL rx_addr: got %h want 01", RSP_ADDRESS_O); end
    tests_run++; if (RSP_DATA_O !== 41'h0_DEAD_BEEF) begin tests_failed++; $display("FAIL rx_data: got %h want deadbeef", RSP_DATA_O); end
    RSP_READY_I = 1'b1; tick; RSP_READY_I = 1'b0;
    tests_run++; if (RSP_VALID_O !== 1'b0) begin tests_failed++; $display("FAIL rx_consume: valid %b want 0", RSP_VALID_O); end
  endtask

  task automatic test_backpressure;
    int upd, vcycle, bad_read, changes;
    logic [W-1:0] held;
    push(1'b1, 8'h01);
    push(1'b0, 8'hEF); push(1'b0, 8'hBE); push(1'b0, 8'hAD); push(1'b0, 8'hDE);
    push(1'b0, 8'h78); push(1'b0, 8'h56); push(1'b0, 8'h34); push(1'b0, 8'h12);
    vcycle = -1;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (RSP_VALID_O) begin vcycle = c + 1; break; end
    end
    tests_run++; if (vcycle < 0 || RSP_DATA_O !== 41'h0_DEAD_BEEF) begin tests_failed++; $display("FAIL bp_first_word: got %h (cycle %0d) want deadbeef", RSP_DATA_O, vcycle); end
    held = RSP_DATA_O; bad_read = 0; changes = 0;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (READ_O) bad_read++;
      if (RSP_DATA_O !== held || !RSP_VALID_O || RX_EMPTY_I) changes++;
    end
    tests_run++; if (bad_read != 0) begin tests_failed++; $display("FAIL bp_read_while_pending: %0d pops want 0", bad_read); end
    tests_run++; if (changes != 0) begin tests_failed++; $display("FAIL bp_stable: %0d cycles unstable want 0", changes); end
    RSP_READY_I = 1'b1; tick; RSP_READY_I = 1'b0;
    upd = 0; vcycle = -1;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (ADDR_UPDATE_O) upd++;
      if (RSP_VALID_O) begin vcycle = c + 1; break; end
    end
    tests_run++; if (vcycle != 4 || upd != 0) begin tests_failed++; $display("FAIL bp_second_timing: cycle %0d upd %0d want 4 0", vcycle, upd); end
    tests_run++; if (RSP_DATA_O !== 41'h0_1234_5678 || RSP_ADDRESS_O !== 5'h01) begin
      tests_failed++; $display("FAIL bp_second_word: got %h @%h want 12345678 @01", RSP_DATA_O, RSP_ADDRESS_O); end
    RSP_READY_I = 1'b1; tick; RSP_READY_I = 1'b0;
  endtask

  task automatic test_abort;
    int upd, vcycle;
    push(1'b1, 8'h01); push(1'b0, 8'hEF); push(1'b0, 8'hBE);
    push(1'b1, 8'h10);
    push(1'b0, 8'h11); push(1'b0, 8'h22); push(1'b0, 8'h33); push(1'b0, 8'h44);
    upd = 0; vcycle = -1;
    for (int c = 0; c < 30; c++) begin
      tick;
      if (ADDR_UPDATE_O) upd++;
      if (RSP_VALID_O) begin vcycle = c + 1; break; end
    end
    tests_run++; if (vcycle != 8) begin tests_failed++; $display("FAIL abort_valid_cycle: got %0d want 8", vcycle); end
    tests_run++; if (upd != 2) begin tests_failed++; $display("FAIL abort_addr_update: got %0d pulses want 2", upd); end
    tests_run++; if (RSP_ADDRESS_O !== 5'h10 || RSP_DATA_O !== 41'h0_4433_2211) begin
      tests_failed++; $display("FAIL abort_word: got %h @%h want 44332211 @10", RSP_DATA_O, RSP_ADDRESS_O); end
    RSP_READY_I = 1'b1; tick; RSP_READY_I = 1'b0;
  endtask

  task automatic test_read_mask;
    int vcycle;
    push(1'b1, 8'h11);
    push(1'b0, 8'h78); push(1'b0, 8'h56); push(1'b0, 8'h34); push(1'b0, 8'h12); push(1'b0, 8'hFF);
    vcycle = -1;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (RSP_VALID_O) begin vcycle = c + 1; break; end
    end
    tests_run++; if (vcycle != 6) begin tests_failed++; $display("FAIL mask_valid_cycle: got %0d want 6", vcycle); end
    tests_run++; if (RSP_DATA_O !== 41'h3_1234_5678 || RSP_ADDRESS_O !== 5'h11) begin
      tests_failed++; $display("FAIL mask_word: got %h @%h want 312345678 @11", RSP_DATA_O, RSP_ADDRESS_O); end
    RSP_READY_I = 1'b1; tick; RSP_READY_I = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit ok;
    int strobes;
    push(1'b1, 8'h10);
    push(1'b0, 8'h01); push(1'b0, 8'h02); push(1'b0, 8'h03); push(1'b0, 8'h04);
    send_req(CMD_WRITE, ADDR_DMI, 41'h1_2345_6789_AB, ok);
    for (int c = 0; c < 6; c++) tick;
    tests_run++; if (!ok || RSP_VALID_O !== 1'b1 || REQ_READY_O !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_setup: ok %b valid %b ready %b want 1 1 0", ok, RSP_VALID_O, REQ_READY_O); end
    RST_NI = 1'b0;
    tick;
    tests_run++; if ({REQ_READY_O, RSP_VALID_O, WRITE_O, SEND_COMMAND_O, ADDR_UPDATE_O, READ_O} !== 6'b0) begin
      tests_failed++; $display("FAIL midrst_strobes: got %b want 000000", {REQ_READY_O, RSP_VALID_O, WRITE_O, SEND_COMMAND_O, ADDR_UPDATE_O, READ_O}); end
    tests_run++; if ({COMMAND_O, DATA_SEND_O} !== 16'h0 || RSP_DATA_O !== '0 || RSP_ADDRESS_O !== ADDR_IDCODE) begin
      tests_failed++; $display("FAIL midrst_values: cmd %h data %h rsp %h addr %h want 0 0 0 01", COMMAND_O, DATA_SEND_O, RSP_DATA_O, RSP_ADDRESS_O); end
    RST_NI = 1'b1;
    tick;
    tests_run++; if (REQ_READY_O !== 1'b1) begin tests_failed++; $display("FAIL midrst_ready: got %b want 1", REQ_READY_O); end
    strobes = 0;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (WRITE_O || SEND_COMMAND_O || RSP_VALID_O) strobes++;
    end
    tests_run++; if (strobes != 0) begin tests_failed++; $display("FAIL midrst_no_resume: %0d activity cycles want 0", strobes); end
  endtask

  initial begin
    RST_NI = 1'b0; REQ_VALID_I = 1'b0; REQ_COMMAND_I = CMD_NOP;
    REQ_ADDRESS_I = '0; REQ_DATA_I = '0; RSP_READY_I = 1'b0; TX_READY_I = 1'b1;
    for (int i = 0; i < 256; i++) rx_mem[i] = 9'h0;
    test_reset;
    test_write_dmi;
    test_write_dtmcs_and_read;
    test_tx_throttle;
    test_rx_basic;
    test_backpressure;
    test_abort;
    test_read_mask;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
